// File: rtl/int_line_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// int_line_conditioner_pkg
//   Shared definitions for the external interrupt line conditioner. The CPU
//   core's ack/mask decoding uses the same line indices and state encodings.
//
//   Contents:
//     INT_A / INT_B          bit index of each line in the 2-bit ack/mask/flag
//                            vectors
//     NUM_LINES              number of conditioned lines
//     DEFAULT_*              default synchroniser depth, debounce length and
//                            debounce counter width
//     chan_state_e           per-line request state (IDLE / PEND)
//     params_legal()         elaboration-time parameter range check
// -----------------------------------------------------------------------------
package int_line_conditioner_pkg;

  localparam int INT_A     = 0;
  localparam int INT_B     = 1;
  localparam int NUM_LINES = 2;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_CNT_W           = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } chan_state_e;

  // Synchroniser depth 2..4, debounce length 1..255, and the counter must be
  // wide enough to hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic logic params_legal(input int sync_stages,
                                        input int debounce_cycles,
                                        input int cnt_w);
    logic ok;
    ok = (sync_stages >= 2) && (sync_stages <= 4) &&
         (debounce_cycles >= 1) && (debounce_cycles <= 255) &&
         (cnt_w >= 1) && (cnt_w <= 30) &&
         ((1 << cnt_w) > debounce_cycles);
    return ok;
  endfunction

endpackage : int_line_conditioner_pkg

// File: rtl/int_line_conditioner_chan.sv
// -----------------------------------------------------------------------------
// int_line_conditioner_chan
//   One conditioned interrupt line: synchroniser, debounce filter, rising-edge
//   detector, pending-request state machine and sticky overrun flag.
//
//   Ports:
//     clk        in  1  CPU clock
//     n_rst      in  1  asynchronous active-low reset
//     i_pin      in  1  raw pin, asynchronous to clk
//     i_ack      in  1  one-cycle acknowledge of a pending request
//     o_pending  out 1  request is pending (registered state)
//     o_overrun  out 1  sticky: a new edge arrived while already pending
// -----------------------------------------------------------------------------
module int_line_conditioner_chan
  import int_line_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_pin,
  input  logic i_ack,
  output logic o_pending,
  output logic o_overrun
);

  generate
    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_params
      $error("int_line_conditioner_chan: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: only the last stage is allowed to feed any logic.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: the filtered level only follows the synchronised pin after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles. Any cycle of agreement
  // restarts the count, so shorter glitches are invisible downstream.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;
  logic             filt_prev_q;
  logic             rise;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_out == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      // Saturating: the count can never wrap back to a small value.
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  // Only a low-to-high transition of the filtered level is an event.
  assign rise = filt_q & ~filt_prev_q;

  // ---------------------------------------------------------------------------
  // Request state machine with sticky overrun.
  //   IDLE: rise -> PEND; ack ignored.
  //   PEND: ack without rise -> IDLE. ack with rise stays PEND (the new event
  //         is kept). rise without ack marks an overrun; ack clears it.
  // Overrun can only be set while PEND and PEND is only left via ack, which
  // clears it, so IDLE never carries a stale overrun.
  // ---------------------------------------------------------------------------
  chan_state_e state_q;
  logic        overrun_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (i_ack) begin
            overrun_q <= 1'b0;
          end else if (rise) begin
            overrun_q <= 1'b1;
          end
          if (i_ack && !rise) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_pending = (state_q == ST_PEND);
  assign o_overrun = overrun_q;

endmodule : int_line_conditioner_chan

// File: rtl/int_line_conditioner.sv
// -----------------------------------------------------------------------------
// int_line_conditioner
//   Front end for the CPU's two external interrupt lines. Each raw pin is
//   synchronised, debounced, rising-edge detected and latched as a pending
//   request until acknowledged. The mask only gates the request outputs; the
//   pending state underneath is kept.
//
//   Ports:
//     clk         in  1  CPU clock (5 MHz)
//     n_rst       in  1  asynchronous active-low reset
//     i_pin_inta  in  1  raw interrupt pin A (asynchronous)
//     i_pin_intb  in  1  raw interrupt pin B (asynchronous)
//     i_ack       in  2  one-cycle acknowledge per line, [0]=A [1]=B
//     i_mask      in  2  1 = suppress that line's request output
//     o_inta      out 1  request A to the CPU core
//     o_intb      out 1  request B to the CPU core
//     o_pending   out 2  raw pending flags, ignoring the mask
//     o_overrun   out 2  sticky overrun flags
//
//   Latency: pin rise ahead of edge 0 shows on o_int* after edge
//   SYNC_STAGES+DEBOUNCE_CYCLES (the SYNC_STAGES+DEBOUNCE_CYCLES+1'th edge).
// -----------------------------------------------------------------------------
module int_line_conditioner
  import int_line_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_pin_inta,
  input  logic       i_pin_intb,
  input  logic [1:0] i_ack,
  input  logic [1:0] i_mask,
  output logic       o_inta,
  output logic       o_intb,
  output logic [1:0] o_pending,
  output logic [1:0] o_overrun
);

  logic [NUM_LINES-1:0] pin_raw;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] overrun;

  assign pin_raw[INT_A] = i_pin_inta;
  assign pin_raw[INT_B] = i_pin_intb;

  // The two lines share nothing but the clock and reset.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_chan
      int_line_conditioner_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_chan (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_pin     (pin_raw[gi]),
        .i_ack     (i_ack[gi]),
        .o_pending (pending[gi]),
        .o_overrun (overrun[gi])
      );
    end
  endgenerate

  // Mask is applied combinationally so that unmasking presents an already
  // pending request in the same cycle.
  assign o_inta    = pending[INT_A] & ~i_mask[INT_A];
  assign o_intb    = pending[INT_B] & ~i_mask[INT_B];
  assign o_pending = pending;
  assign o_overrun = overrun;

endmodule : int_line_conditioner

// File: tb/tb_int_line_conditioner.sv
// -----------------------------------------------------------------------------
// tb_int_line_conditioner
//   Directed bench for int_line_conditioner with default parameters
//   (SYNC_STAGES=2, DEBOUNCE_CYCLES=16: pin-to-request latency of 19 edges).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_int_line_conditioner;

  logic       clk;
  logic       n_rst;
  logic       i_pin_inta;
  logic       i_pin_intb;
  logic [1:0] i_ack;
  logic [1:0] i_mask;
  logic       o_inta;
  logic       o_intb;
  logic [1:0] o_pending;
  logic [1:0] o_overrun;

  int vectors;
  int miscompares;

  int_line_conditioner dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_pin_inta (i_pin_inta),
    .i_pin_intb (i_pin_intb),
    .i_ack      (i_ack),
    .i_mask     (i_mask),
    .o_inta     (o_inta),
    .o_intb     (o_intb),
    .o_pending  (o_pending),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_rst      = 1'b0;
    i_pin_inta = 1'b0;
    i_pin_intb = 1'b0;
    i_ack      = 2'b00;
    i_mask     = 2'b00;
    tick(3);
    vectors++;
    if ({o_inta, o_intb, o_pending, o_overrun} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_held outs got=%b exp=%b", {o_inta, o_intb, o_pending, o_overrun}, 6'b0);
    end
    n_rst = 1'b1;
    tick(1);
    vectors++;
    if ({o_inta, o_intb, o_pending, o_overrun} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_release outs got=%b exp=%b", {o_inta, o_intb, o_pending, o_overrun}, 6'b0);
    end
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_latency();
    i_pin_inta = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      vectors++;
      if (o_inta !== 1'b0 || o_intb !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early edge=%0d inta=%b intb=%b exp=0 0", i, o_inta, o_intb);
      end
    end
    tick(1);
    vectors++;
    if (o_inta !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_19 inta got=%b exp=1", o_inta);
    end
    vectors++;
    if (o_pending !== 2'b01) begin
      miscompares++;
      $display("FAIL latency_pending got=%b exp=01", o_pending);
    end
    for (int i = 0; i < 21; i++) begin
      tick(1);
      vectors++;
      if (o_intb !== 1'b0 || o_inta !== 1'b1) begin
        miscompares++;
        $display("FAIL latency_hold cyc=%0d inta=%b intb=%b exp=1 0", i, o_inta, o_intb);
      end
    end
    $display("test_latency done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    i_pin_intb = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) i_pin_intb = 1'b0;
      tick(1);
      vectors++;
      if (o_intb !== 1'b0 || o_pending[1] !== 1'b0 || o_overrun !== 2'b00) begin
        miscompares++;
        $display("FAIL glitch_b cyc=%0d intb=%b pend=%b ovr=%b exp=0 0x 00", i, o_intb, o_pending, o_overrun);
      end
    end
    $display("test_glitch done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ack();
    i_ack = 2'b01;
    #1;
    vectors++;
    if (o_inta !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_before_edge inta got=%b exp=1", o_inta);
    end
    tick(1);
    i_ack = 2'b00;
    vectors++;
    if (o_inta !== 1'b0 || o_pending !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_clear inta=%b pend=%b exp=0 00", o_inta, o_pending);
    end
    i_ack = 2'b01;
    tick(1);
    i_ack = 2'b00;
    tick(3);
    vectors++;
    if (o_inta !== 1'b0 || o_pending !== 2'b00 || o_overrun !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_idle inta=%b pend=%b ovr=%b exp=0 00 00", o_inta, o_pending, o_overrun);
    end
    $display("test_ack done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overrun();
    // Line A is idle with the pin still high: fall then rise to re-arm.
    i_pin_inta = 1'b0;
    tick(20);
    i_pin_inta = 1'b1;
    tick(20);
    vectors++;
    if (o_pending !== 2'b01 || o_overrun !== 2'b00) begin
      miscompares++;
      $display("FAIL ovr_arm pend=%b ovr=%b exp=01 00", o_pending, o_overrun);
    end
    i_pin_inta = 1'b0;
    tick(20);
    vectors++;
    if (o_pending !== 2'b01 || o_overrun !== 2'b00) begin
      miscompares++;
      $display("FAIL ovr_fall pend=%b ovr=%b exp=01 00", o_pending, o_overrun);
    end
    i_pin_inta = 1'b1;
    tick(20);
    vectors++;
    if (o_overrun !== 2'b01 || o_pending !== 2'b01 || o_inta !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set ovr=%b pend=%b inta=%b exp=01 01 1", o_overrun, o_pending, o_inta);
    end
    i_ack = 2'b01;
    tick(1);
    i_ack = 2'b00;
    vectors++;
    if (o_overrun !== 2'b00 || o_pending !== 2'b00 || o_inta !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_ack ovr=%b pend=%b inta=%b exp=00 00 0", o_overrun, o_pending, o_inta);
    end
    i_pin_inta = 1'b0;
    tick(20);
    $display("test_overrun done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mask();
    i_mask     = 2'b11;
    i_pin_inta = 1'b1;
    i_pin_intb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      vectors++;
      if (o_inta !== 1'b0 || o_intb !== 1'b0) begin
        miscompares++;
        $display("FAIL mask_outs cyc=%0d inta=%b intb=%b exp=0 0", i, o_inta, o_intb);
      end
    end
    vectors++;
    if (o_pending !== 2'b11) begin
      miscompares++;
      $display("FAIL mask_pending got=%b exp=11", o_pending);
    end
    i_mask = 2'b00;
    #1;
    vectors++;
    if (o_inta !== 1'b1 || o_intb !== 1'b1) begin
      miscompares++;
      $display("FAIL mask_release inta=%b intb=%b exp=1 1", o_inta, o_intb);
    end
    i_ack = 2'b11;
    tick(1);
    i_ack = 2'b00;
    vectors++;
    if (o_pending !== 2'b00 || o_inta !== 1'b0 || o_intb !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_ack pend=%b inta=%b intb=%b exp=00 0 0", o_pending, o_inta, o_intb);
    end
    $display("test_mask done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    i_pin_inta = 1'b0;
    i_pin_intb = 1'b0;
    tick(20);
    i_pin_inta = 1'b1;
    tick(20);
    vectors++;
    if (o_pending !== 2'b01 || o_inta !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_arm pend=%b inta=%b exp=01 1", o_pending, o_inta);
    end
    // B counter reaches 8 after the tenth edge from the pin change.
    i_pin_intb = 1'b1;
    tick(10);
    #2;
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({o_inta, o_intb, o_pending, o_overrun} !== 6'b0) begin
      miscompares++;
      $display("FAIL rmid_async outs got=%b exp=%b", {o_inta, o_intb, o_pending, o_overrun}, 6'b0);
    end
    tick(2);
    n_rst = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      vectors++;
      if ({o_inta, o_intb, o_pending} !== 4'b0) begin
        miscompares++;
        $display("FAIL rmid_relatch edge=%0d outs got=%b exp=0000", i, {o_inta, o_intb, o_pending});
      end
    end
    tick(1);
    vectors++;
    if (o_inta !== 1'b1 || o_intb !== 1'b1 || o_pending !== 2'b11) begin
      miscompares++;
      $display("FAIL rmid_19 inta=%b intb=%b pend=%b exp=1 1 11", o_inta, o_intb, o_pending);
    end
    $display("test_reset_mid done");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_ack();
    test_overrun();
    test_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_int_line_conditioner
